// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Brief    : Two-requester access bus between hosts and the SRAM arbiter.
// Revision : 1.0
// ============================================================================
interface sram_arbiter_if;
  logic        req0;
  logic        req1;
  logic        wr0;
  logic        wr1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] rdata;
  logic        busy;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Two-port arbiter driving an async SRAM, 4 cycles per access.
//            Define SRAM_ARB_RR_EN for round-robin instead of fixed priority.
// Revision : 1.0
// ============================================================================
module sram_arbiter (
  input  wire           clk,
  input  wire           reset,
  sram_arbiter_if.slave host,
  output logic [15:0]   mem_addr,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  inout  wire  [15:0]   mem_data_io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic        w_take;
  logic        w_win;
  logic        w_drive;

  logic        r_wr;
  logic        r_id;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;

  // w_win: 0 selects requester 0, 1 selects requester 1
`ifdef SRAM_ARB_RR_EN
  logic r_last;

  always_comb begin
    w_win = ~host.req0;
    if (host.req0 && host.req1) begin
      w_win = ~r_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_take) begin
      r_last <= w_win;
    end
  end
`else
  always_comb begin
    w_win = ~host.req0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_take     = 1'b0;
    case (r_state)
      IDLE: begin
        if (host.req0 || host.req1) begin
          w_take     = 1'b1;
          w_state_nx = SETUP;
        end
      end
      SETUP:   w_state_nx = STROBE;
      STROBE:  w_state_nx = HOLD;
      HOLD:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_id    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_gnt0  <= w_take & ~w_win;
      r_gnt1  <= w_take &  w_win;
      r_done0 <= (r_state == HOLD) & ~r_id;
      r_done1 <= (r_state == HOLD) &  r_id;
      if (w_take) begin
        r_id    <= w_win;
        r_wr    <= w_win ? host.wr1    : host.wr0;
        r_addr  <= w_win ? host.addr1  : host.addr0;
        r_wdata <= w_win ? host.wdata1 : host.wdata0;
      end
      // Output enable is still low in HOLD, so the bus is stable here
      if ((r_state == HOLD) && !r_wr) begin
        r_rdata <= mem_data_io;
      end
    end
  end

  assign w_drive     = r_wr && (r_state != IDLE);
  assign mem_addr    = r_addr;
  assign mem_we_n    = ~(r_wr && (r_state == STROBE));
  assign mem_oe_n    = ~(!r_wr && ((r_state == STROBE) || (r_state == HOLD)));
  assign mem_data_io = w_drive ? r_wdata : 16'hzzzz;

  assign host.gnt0  = r_gnt0;
  assign host.gnt1  = r_gnt1;
  assign host.done0 = r_done0;
  assign host.done1 = r_done1;
  assign host.rdata = r_rdata;
  assign host.busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Self-checking bench for sram_arbiter with an SRAM model and a
//            per-cycle transaction-level reference.
// Revision : 1.0
// ============================================================================
module tb_sram_arbiter;
  localparam int NCYC = 8000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   errs  = 0;
  int   checks = 0;
  int   gnt0_cnt = 0;
  int   gnt1_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter_if bus_if ();
  wire [15:0] mem_addr;
  wire        mem_we_n;
  wire        mem_oe_n;
  tri1 [15:0] mem_data_io;

  sram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .host        (bus_if),
    .mem_addr    (mem_addr),
    .mem_we_n    (mem_we_n),
    .mem_oe_n    (mem_oe_n),
    .mem_data_io (mem_data_io)
  );

  // Async SRAM: drives while output-enabled, stores mid-cycle of a write strobe
  logic [15:0] sram [0:65535];
  logic [15:0] mmem [0:65535];
  assign mem_data_io = mem_oe_n ? 16'hzzzz : sram[mem_addr];
  always @(negedge clk) if (!reset && !mem_we_n) sram[mem_addr] = mem_data_io;

  // Expected per-cycle outputs, filled in when the model accepts a request
  bit          e_g0 [NCYC];
  bit          e_g1 [NCYC];
  bit          e_d0 [NCYC];
  bit          e_d1 [NCYC];
  bit          e_busy [NCYC];
  bit          e_welow [NCYC];
  bit          e_oelow [NCYC];
  bit          e_bdef [NCYC];
  logic [15:0] e_bval [NCYC];
  bit          e_aset [NCYC];
  logic [15:0] e_aval [NCYC];
  bit          e_rset [NCYC];
  logic [15:0] e_rval [NCYC];

  int          free = 0;
  bit          last = 1'b1;
  logic [15:0] undo_addr = 16'h0;
  logic [15:0] undo_val  = 16'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Applies one cycle of inputs; the model decides acceptance from plain rules
  task automatic step(input bit r0, input bit w0, input logic [15:0] a0, input logic [15:0] d0,
                      input bit r1, input bit w1, input logic [15:0] a1, input logic [15:0] d1);
    int          a;
    bit          win;
    bit          wr;
    logic [15:0] ad;
    logic [15:0] wd;
    bus_if.req0 = r0; bus_if.wr0 = w0; bus_if.addr0 = a0; bus_if.wdata0 = d0;
    bus_if.req1 = r1; bus_if.wr1 = w1; bus_if.addr1 = a1; bus_if.wdata1 = d1;
    if (cyc >= free && (r0 || r1)) begin
      if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
        win = !last;
`else
        win = 1'b0;
`endif
      end else begin
        win = r1;
      end
      last = win;
      wr = win ? w1 : w0;
      ad = win ? a1 : a0;
      wd = win ? d1 : d0;
      a  = cyc + 1;
      if (win) e_g1[a] = 1'b1; else e_g0[a] = 1'b1;
      if (win) e_d1[a+3] = 1'b1; else e_d0[a+3] = 1'b1;
      e_aset[a] = 1'b1;
      e_aval[a] = ad;
      for (int j = 0; j < 3; j++) e_busy[a+j] = 1'b1;
      if (wr) begin
        for (int j = 0; j < 3; j++) begin
          e_bdef[a+j] = 1'b1;
          e_bval[a+j] = wd;
        end
        e_welow[a+1] = 1'b1;
        undo_addr = ad;
        undo_val  = mmem[ad];
        mmem[ad]  = wd;
      end else begin
        for (int j = 1; j < 3; j++) begin
          e_oelow[a+j] = 1'b1;
          e_bdef[a+j]  = 1'b1;
          e_bval[a+j]  = mmem[ad];
        end
        e_rset[a+3] = 1'b1;
        e_rval[a+3] = mmem[ad];
      end
      free = cyc + 4;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic wait_idle();
    while (cyc < free) idle_step();
  endtask

  task automatic issue(input bit port, input bit wr, input logic [15:0] ad,
                       input logic [15:0] wd, output int g);
    wait_idle();
    if (port) step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, wr, ad, wd);
    else      step(1'b1, wr, ad, wd, 1'b0, 1'b0, 16'h0, 16'h0);
    g = cyc;
  endtask

  // Compare process: every cycle outside reset
  initial begin : compare
    logic [15:0] m_addr;
    logic [15:0] m_rd;
    int          c;
    m_addr = 16'h0;
    m_rd   = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_addr = 16'h0;
        m_rd   = 16'h0;
      end else if (cyc < NCYC) begin
        c = cyc;
        if (e_aset[c]) m_addr = e_aval[c];
        if (e_rset[c]) m_rd   = e_rval[c];
        if (bus_if.gnt0) gnt0_cnt++;
        if (bus_if.gnt1) gnt1_cnt++;
        chk("gnt0",     bus_if.gnt0,  e_g0[c]);
        chk("gnt1",     bus_if.gnt1,  e_g1[c]);
        chk("done0",    bus_if.done0, e_d0[c]);
        chk("done1",    bus_if.done1, e_d1[c]);
        chk("busy",     bus_if.busy,  e_busy[c]);
        chk("mem_we_n", mem_we_n,     !e_welow[c]);
        chk("mem_oe_n", mem_oe_n,     !e_oelow[c]);
        chk("mem_addr", mem_addr,     m_addr);
        chk("rdata",    bus_if.rdata, m_rd);
        chk("data_bus", mem_data_io,  e_bdef[c] ? e_bval[c] : 16'hFFFF);
        chk("strobe_overlap", (!mem_we_n && !mem_oe_n), 1'b0);
      end
    end
  end

  initial begin : driver
    int g;
    int n0;
    int n1;
    for (int i = 0; i < 65536; i++) begin
      sram[i] = 16'(i) ^ 16'h5A5A;
      mmem[i] = 16'(i) ^ 16'h5A5A;
    end
    bus_if.req0 = 1'b0; bus_if.wr0 = 1'b0; bus_if.addr0 = 16'h0; bus_if.wdata0 = 16'h0;
    bus_if.req1 = 1'b0; bus_if.wr1 = 1'b0; bus_if.addr1 = 16'h0; bus_if.wdata1 = 16'h0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy",  bus_if.busy,  1'b0);
    chk("rst_gnt",   {bus_if.gnt0, bus_if.gnt1, bus_if.done0, bus_if.done1}, 4'b0000);
    chk("rst_we_n",  mem_we_n,     1'b1);
    chk("rst_oe_n",  mem_oe_n,     1'b1);
    chk("rst_addr",  mem_addr,     16'h0000);
    chk("rst_rdata", bus_if.rdata, 16'h0000);
    chk("rst_bus",   mem_data_io,  16'hFFFF);
    reset = 1'b0;
    #1;
    free = cyc;

    // Write then read back through the other port, back-to-back
    issue(1'b0, 1'b1, 16'h00A0, 16'h1234, g);
    chk("wr_gnt0", bus_if.gnt0, 1'b1);
    chk("model_done_lat", e_d0[g+3], 1'b1);
    repeat (3) idle_step();
    chk("wr_done0", bus_if.done0, 1'b1);
    issue(1'b1, 1'b0, 16'h00A0, 16'h0000, g);
    chk("rd_gnt1", bus_if.gnt1, 1'b1);
    repeat (3) idle_step();
    chk("rd_done1", bus_if.done1, 1'b1);
    chk("rd_rdata", bus_if.rdata, 16'h1234);

    // Both requesters held for four accesses
    wait_idle();
    n0 = gnt0_cnt;
    n1 = gnt1_cnt;
    repeat (16) step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
`ifdef SRAM_ARB_RR_EN
    chk("tie_gnt0_count", gnt0_cnt - n0, 2);
    chk("tie_gnt1_count", gnt1_cnt - n1, 2);
`else
    chk("tie_gnt0_count", gnt0_cnt - n0, 4);
    chk("tie_gnt1_count", gnt1_cnt - n1, 0);
`endif

    // Top of the address space
    issue(1'b0, 1'b1, 16'hFFFF, 16'hBEEF, g);
    chk("top_addr_setup", mem_addr, 16'hFFFF);
    idle_step();
    chk("top_addr_strobe", mem_addr, 16'hFFFF);
    chk("top_we_strobe", mem_we_n, 1'b0);
    idle_step();
    chk("top_addr_hold", mem_addr, 16'hFFFF);
    chk("top_we_hold", mem_we_n, 1'b1);
    issue(1'b1, 1'b0, 16'hFFFF, 16'h0000, g);
    repeat (3) idle_step();
    chk("top_rdata", bus_if.rdata, 16'hBEEF);

    // Randomized traffic over a small address window to hit read-after-write
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) == 0, $urandom % 2, 16'h0100 + 16'($urandom % 8), 16'($urandom),
           ($urandom % 3) == 0, $urandom % 2, 16'h0100 + 16'($urandom % 8), 16'($urandom));
    end

    // Reset in the strobe cycle of a write abandons it
    issue(1'b0, 1'b1, 16'h0104, 16'hA55A, g);
    idle_step();
    chk("mid_we_low", mem_we_n, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_we_n", mem_we_n, 1'b1);
    chk("mid_rst_oe_n", mem_oe_n, 1'b1);
    chk("mid_rst_bus",  mem_data_io, 16'hFFFF);
    chk("mid_rst_busy", bus_if.busy, 1'b0);
    for (int c = cyc; c < NCYC; c++) begin
      e_g0[c] = 1'b0; e_g1[c] = 1'b0; e_d0[c] = 1'b0; e_d1[c] = 1'b0;
      e_busy[c] = 1'b0; e_welow[c] = 1'b0; e_oelow[c] = 1'b0; e_bdef[c] = 1'b0;
      e_aset[c] = 1'b0; e_rset[c] = 1'b0;
    end
    mmem[undo_addr] = undo_val;
    last = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    free = cyc;
    chk("post_rst_done", bus_if.done0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 2) == 0, $urandom % 2, 16'h0100 + 16'($urandom % 8), 16'($urandom),
           ($urandom % 2) == 0, $urandom % 2, 16'h0100 + 16'($urandom % 8), 16'($urandom));
    end
    wait_idle();
    repeat (2) idle_step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (16-bit address, 16-bit data).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0 / req1  input  1  access request, requester 0 / 1.
REQ-005 SHALL have ports wr0 / wr1  input  1  1 = write, 0 = read; valid with req.
REQ-006 SHALL have ports addr0 / addr1  input  16  access address; valid with req.
REQ-007 SHALL have ports wdata0 / wdata1  input  16  write data; valid with req.
REQ-008 SHALL have ports gnt0 / gnt1  output  1  one-cycle pulse: request accepted, fields latched.
REQ-009 SHALL have ports done0 / done1  output  1  one-cycle pulse: access complete.
REQ-010 SHALL have port rdata  output  16  read data, valid in the cycle doneN is high after a read.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have ports mem_addr  output  16, mem_we_n  output  1, mem_oe_n  output  1, mem_data_io  inout  16  async SRAM side (active-low strobes).

Function
REQ-013 FSM states SHALL be IDLE, SETUP, STROBE, HOLD; path IDLE->SETUP->STROBE->HOLD->IDLE, one cycle per state.
REQ-014 In IDLE with any req high, the FSM SHALL latch the winner's wr/addr/wdata, pulse its gnt, and enter SETUP on the same edge.
REQ-015 SETUP: mem_addr = latched addr, both strobes high; on a write, mem_data_io driven with latched wdata.
REQ-016 STROBE: write -> mem_we_n low; read -> mem_oe_n low; address (and write data) held.
REQ-017 HOLD: write -> mem_we_n high, data still driven; read -> mem_oe_n stays low, rdata captured from mem_data_io on the edge leaving HOLD.
REQ-018 doneN SHALL pulse in the first cycle after HOLD (FSM in IDLE); gnt-to-done latency is exactly 3 cycles, 4 cycles per access.
REQ-019 A new request SHALL be accepted in the same IDLE cycle that done is high (back-to-back throughput: one access per 4 cycles).
REQ-020 mem_data_io SHALL be high-Z except during SETUP/STROBE/HOLD of a write; never driven while mem_oe_n is low.
REQ-021 mem_we_n and mem_oe_n SHALL never be low simultaneously.
REQ-022 rdata SHALL retain its last value until the next read completes; writes do not alter it.
REQ-023 Requests arriving while busy SHALL be ignored until IDLE; req may drop after gnt without affecting the access.
REQ-024 Default arbitration: fixed priority, requester 0 wins when req0 and req1 are both high.

Reset
REQ-025 On reset assertion, immediately: FSM IDLE, mem_we_n = 1, mem_oe_n = 1, mem_data_io high-Z, mem_addr = 0, gnt0/1 = 0, done0/1 = 0, busy = 0, rdata = 0.
REQ-026 Reset mid-access SHALL abandon the access with no done pulse; the first request after reset release is sampled on the first rising edge.

Configuration
REQ-027 Macro SRAM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests the requester not served last wins; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-028 SRAM_ARB_RR_EN undefined: fixed priority per REQ-024; no pointer register is built.

Verification
REQ-029 Write 0x1234 to 0x00A0 on port 0, then read 0x00A0 on port 1 -> gnt0, done0 3 cycles later; done1 with rdata = 0x1234.
REQ-030 req0 and req1 held high for 4 accesses -> fixed: gnt0 x4, gnt1 none; with SRAM_ARB_RR_EN: gnt0, gnt1, gnt0, gnt1.
REQ-031 Write to 0xFFFF with 0xBEEF, read back -> rdata = 0xBEEF; mem_addr = 0xFFFF through SETUP..HOLD.
REQ-032 Assert reset during STROBE of a write -> mem_we_n = 1, data high-Z same cycle, no done, busy = 0.
REQ-033 Continuous strobe checker across all tests -> mem_we_n and mem_oe_n never both low; mem_data_io never driven while mem_oe_n = 0.
